// File: rtl/md5crypt_pkg.sv
// Shared constants and types for the md5crypt unit input path.
//   PKT_TYPE_DATA     header byte of a data packet
//   PKT_TYPE_INIT     low 3 bits of an init ctrl byte
//   PKT_HDR_LEN       payload bytes that precede the key
//   PKT_KEYLEN_OFFSET payload offset of the key_len byte
//   MIN_PKT_LEN       shortest legal payload (header fields + one key word)
package md5crypt_pkg;

  localparam logic [7:0]  PKT_TYPE_DATA     = 8'h00;
  localparam logic [2:0]  PKT_TYPE_INIT     = 3'b001;
  localparam int unsigned PKT_HDR_LEN       = 40;
  localparam int unsigned PKT_KEYLEN_OFFSET = 32;
  localparam int unsigned MIN_PKT_LEN       = 44;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_INIT_HOLD,
    ST_DISCARD
  } unit_in_state_e;

  // Payload length implied by a key length: header fields plus the key
  // rounded up to whole 32-bit words.
  function automatic int unsigned exp_pkt_len(input logic [6:0] key_len);
    int unsigned kl;
    kl = 32'(key_len);
    return PKT_HDR_LEN + ((kl + 32'd3) & ~32'd3);
  endfunction

endpackage

// File: rtl/unit_input_packer.sv
// Byte-to-word packer for the unit input buffer.
// Collects bytes little-endian into 32-bit words; the word write strobe fires
// on every 4th byte together with the word index and the assembled word.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          restart the byte counter at the start of a packet
//   i_byte_en        accept i_byte at the current byte count
//   i_byte           incoming byte
//   o_byte_cnt       bytes accepted since the last clear
//   o_word_we        a complete word is presented this cycle
//   o_word_addr      word index of the presented word
//   o_word_data      presented word (current byte in bits [31:24])
module unit_input_packer #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_byte_en,
  input  logic [7:0]       i_byte,
  output logic [CNT_W-1:0] o_byte_cnt,
  output logic             o_word_we,
  output logic [CNT_W-3:0] o_word_addr,
  output logic [31:0]      o_word_data
);

  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_byte_en) begin
      r_cnt <= r_cnt + 1'b1;
      case (r_cnt[1:0])
        2'd0:    r_acc[7:0]   <= i_byte;
        2'd1:    r_acc[15:8]  <= i_byte;
        2'd2:    r_acc[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

  // Lane 3 completes the word; it goes straight to the RAM without being held.
  assign o_byte_cnt  = r_cnt;
  assign o_word_we   = i_byte_en && (r_cnt[1:0] == 2'd3);
  assign o_word_addr = r_cnt[CNT_W-1:2];
  assign o_word_data = {i_byte, r_acc};

endmodule

// File: rtl/unit_input_buf.sv
// Per-unit receive buffer in front of an md5crypt computing unit.
// Takes the arbiter byte stream (data packets and init bytes), packs data
// packets into a 2-slot word RAM and hands complete packets to the core.
// Optional build macro: UNIT_INPUT_LEN_CHECK_EN -- when defined, a packet is
// only committed if its length matches its key_len field (key_len 1..WORD_MAX_LEN).
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   in_data      broadcast byte from the arbiter
//   in_ctrl      header/init byte, or last byte of a data packet
//   in_wr_en     byte strobe for this unit
//   ready        free slot and no packet in progress (registered)
//   afull        no free slot for the next packet (registered)
//   init_data    payload of the last init byte
//   init_valid   one-cycle pulse when init_data is updated
//   pkt_avail    the read slot holds a complete packet
//   key_len      key_len byte of the available packet
//   rd_addr      word address within the available packet
//   rd_data      word at rd_addr, one cycle latency
//   pkt_done     core releases the available packet
//   err          sticky protocol error
module unit_input_buf
  import md5crypt_pkg::*;
#(
  parameter int unsigned WORD_MAX_LEN = 64,
  parameter int unsigned PKT_LEN      = WORD_MAX_LEN + 40,
  parameter int unsigned PKT_WORDS    = PKT_LEN / 4,
  parameter int unsigned RD_AW        = $clog2(PKT_WORDS)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       in_data,
  input  logic             in_ctrl,
  input  logic             in_wr_en,
  output logic             ready,
  output logic             afull,
  output logic [4:0]       init_data,
  output logic             init_valid,
  output logic             pkt_avail,
  output logic [6:0]       key_len,
  input  logic [RD_AW-1:0] rd_addr,
  output logic [31:0]      rd_data,
  input  logic             pkt_done,
  output logic             err
);

  localparam int unsigned CNT_W  = $clog2(PKT_LEN + 1);
  localparam int unsigned RAM_AW = $clog2(2 * PKT_WORDS);
  localparam logic [CNT_W-1:0] C_PKT_LEN    = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0] C_KEYLEN_OFS = CNT_W'(PKT_KEYLEN_OFFSET);
  localparam logic [CNT_W:0]   C_MIN_LEN    = (CNT_W + 1)'(MIN_PKT_LEN);

  unit_in_state_e r_state, w_state_next;

  logic [1:0]  r_full, w_full_next;
  logic        r_wr_slot, w_wr_slot_next;
  logic        r_rd_slot, w_rd_slot_next;
  logic        r_ready, r_afull, r_err;
  logic [4:0]  r_init_data;
  logic        r_init_valid;
  logic [6:0]  r_keylen [2];
  logic [31:0] r_rd_data;
  logic [31:0] r_ram [2*PKT_WORDS];

  logic             w_clear, w_byte_en, w_commit, w_fsm_err, w_init_load;
  logic [CNT_W-1:0] w_byte_cnt;
  logic [CNT_W:0]   w_total;
  logic             w_base_ok, w_len_ok;
  logic             w_word_we;
  logic [CNT_W-3:0] w_word_addr;
  logic [31:0]      w_word_data;
  logic [RAM_AW-1:0] w_wr_idx, w_rd_idx;
  logic             w_pkt_avail, w_done_ok;

  unit_input_packer #(
    .CNT_W (CNT_W)
  ) u_packer (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_clear     (w_clear),
    .i_byte_en   (w_byte_en),
    .i_byte      (in_data),
    .o_byte_cnt  (w_byte_cnt),
    .o_word_we   (w_word_we),
    .o_word_addr (w_word_addr),
    .o_word_data (w_word_data)
  );

  assign w_total   = {1'b0, w_byte_cnt} + 1'b1;
  assign w_base_ok = (w_total[1:0] == 2'b00) && (w_total >= C_MIN_LEN);

`ifdef UNIT_INPUT_LEN_CHECK_EN
  assign w_len_ok = w_base_ok
                 && (r_keylen[r_wr_slot] != '0)
                 && (32'(r_keylen[r_wr_slot]) <= WORD_MAX_LEN)
                 && (32'(w_total) == exp_pkt_len(r_keylen[r_wr_slot]));
`else
  assign w_len_ok = w_base_ok;
`endif

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_byte_en    = 1'b0;
    w_commit     = 1'b0;
    w_fsm_err    = 1'b0;
    w_init_load  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_wr_en) begin
          if (!in_ctrl) begin
            w_fsm_err = 1'b1;
          end else if (in_data[2:0] == PKT_TYPE_INIT) begin
            w_init_load  = 1'b1;
            w_state_next = ST_INIT_HOLD;
          end else if (in_data == PKT_TYPE_DATA) begin
            w_clear      = 1'b1;
            w_state_next = ST_RECV;
          end else begin
            w_fsm_err = 1'b1;
          end
        end
      end
      ST_INIT_HOLD: begin
        if (!in_wr_en) w_state_next = ST_IDLE;
      end
      ST_RECV: begin
        if (in_wr_en) begin
          if (in_ctrl) begin
            // A final byte past the slot is never stored; its length check fails anyway.
            w_byte_en    = (w_byte_cnt != C_PKT_LEN);
            w_commit     = w_len_ok;
            w_fsm_err    = !w_len_ok;
            w_state_next = ST_IDLE;
          end else if (w_byte_cnt == C_PKT_LEN) begin
            w_fsm_err    = 1'b1;
            w_state_next = ST_DISCARD;
          end else begin
            w_byte_en = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (in_wr_en && in_ctrl) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_pkt_avail = r_full[r_rd_slot];
  assign w_done_ok   = pkt_done && w_pkt_avail;

  // Release and commit touch their own slot, so both apply in one cycle.
  always_comb begin
    w_full_next    = r_full;
    w_rd_slot_next = r_rd_slot;
    w_wr_slot_next = r_wr_slot;
    if (w_done_ok) begin
      w_full_next[r_rd_slot] = 1'b0;
      w_rd_slot_next         = ~r_rd_slot;
    end
    if (w_commit) begin
      w_full_next[r_wr_slot] = 1'b1;
      w_wr_slot_next         = ~r_wr_slot;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_full       <= '0;
      r_wr_slot    <= 1'b0;
      r_rd_slot    <= 1'b0;
      r_ready      <= 1'b0;
      r_afull      <= 1'b1;
      r_err        <= 1'b0;
      r_init_data  <= '0;
      r_init_valid <= 1'b0;
      r_keylen[0]  <= '0;
      r_keylen[1]  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_full       <= w_full_next;
      r_wr_slot    <= w_wr_slot_next;
      r_rd_slot    <= w_rd_slot_next;
      // Flow control is computed from next-state values so it is current
      // in the cycle right after a commit or release.
      r_ready      <= (w_state_next == ST_IDLE) && !w_full_next[w_wr_slot_next];
      r_afull      <= w_full_next[w_wr_slot_next];
      r_init_valid <= w_init_load;
      if (w_fsm_err || (pkt_done && !w_pkt_avail)) r_err <= 1'b1;
      if (w_init_load) r_init_data <= in_data[7:3];
      if (w_byte_en && (w_byte_cnt == C_KEYLEN_OFS)) r_keylen[r_wr_slot] <= in_data[6:0];
    end
  end

  assign w_wr_idx = RAM_AW'(w_word_addr) + (r_wr_slot ? RAM_AW'(PKT_WORDS) : '0);
  assign w_rd_idx = RAM_AW'(rd_addr)     + (r_rd_slot ? RAM_AW'(PKT_WORDS) : '0);

  always_ff @(posedge CLK) begin
    if (w_word_we) r_ram[w_wr_idx] <= w_word_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_data <= '0;
    end else if (32'(rd_addr) < PKT_WORDS) begin
      r_rd_data <= r_ram[w_rd_idx];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign ready      = r_ready;
  assign afull      = r_afull;
  assign init_data  = r_init_data;
  assign init_valid = r_init_valid;
  assign pkt_avail  = w_pkt_avail;
  assign key_len    = r_keylen[r_rd_slot];
  assign rd_data    = r_rd_data;
  assign err        = r_err;

endmodule

// File: tb/tb_unit_input_buf.sv
module tb_unit_input_buf;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ctrl = 1'b0;
  logic        in_wr_en = 1'b0;
  logic        ready, afull, init_valid, pkt_avail, err;
  logic [4:0]  init_data;
  logic [6:0]  key_len;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        pkt_done = 1'b0;

  always #5 CLK = ~CLK;

  unit_input_buf dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_wr_en   (in_wr_en),
    .ready      (ready),
    .afull      (afull),
    .init_data  (init_data),
    .init_valid (init_valid),
    .pkt_avail  (pkt_avail),
    .key_len    (key_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pkt_done   (pkt_done),
    .err        (err)
  );

  typedef struct {
    int unsigned len;
    logic [7:0]  b [128];
  } pkt_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  pkt_t        exp_pkt_q [$];
  logic [4:0]  exp_init_q [$];
  int          occ = 0;
  bit          exp_err = 1'b0;
  bit          cons_auto = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Acceptance rule for a data packet of len payload bytes carrying key length kl.
  function automatic bit pkt_ok(input int unsigned len, input int unsigned kl);
    if (len > 104 || len < 44 || (len % 4) != 0) return 1'b0;
`ifdef UNIT_INPUT_LEN_CHECK_EN
    if (kl < 1 || kl > 64) return 1'b0;
    if (len != 40 + ((kl + 3) / 4) * 4) return 1'b0;
`else
    if (kl > 255) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; leaves at posedge+1 with the strobe sampled.
  task automatic strobe(input logic [7:0] d, input logic c);
    in_data  = d;
    in_ctrl  = c;
    in_wr_en = 1'b1;
    @(posedge CLK);
    #1;
    in_wr_en = 1'b0;
    in_ctrl  = 1'b0;
  endtask

  task automatic send_packet(input int unsigned len, input int unsigned kl, input bit done_last);
    pkt_t p;
    p.len = len;
    for (int unsigned i = 0; i < 128; i++) p.b[i] = 8'($urandom);
    p.b[32] = 8'(kl);
    if (pkt_ok(len, kl)) begin
      exp_pkt_q.push_back(p);
      occ++;
    end else begin
      exp_err = 1'b1;
    end
    strobe(8'h00, 1'b1);
    for (int unsigned i = 0; i < len; i++) begin
      if (i == len - 1 && done_last) pkt_done = 1'b1;
      strobe(p.b[i], (i == len - 1));
      pkt_done = 1'b0;
    end
    if (done_last) occ--;
  endtask

  task automatic send_init(input logic [4:0] v);
    exp_init_q.push_back(v);
    strobe({v, 3'b001}, 1'b1);
    strobe({v, 3'b001}, 1'b1);
    idle(1);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 400) begin
      idle(1);
      k++;
    end
    check("ready_wait", {31'b0, ready}, 32'd1);
  endtask

  // Reads the available packet word by word against the oldest expected packet.
  task automatic read_check_pkt(input bit do_done);
    pkt_t p;
    if (exp_pkt_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pkt_unexpected: got pkt_avail=%0b, required no packet", pkt_avail);
    end else begin
      p = exp_pkt_q.pop_front();
      check("key_len", {25'b0, key_len}, {25'b0, p.b[32][6:0]});
      for (int unsigned w = 0; w < p.len / 4; w++) begin
        @(negedge CLK);
        rd_addr = 5'(w);
        @(negedge CLK);
        check("rd_data", rd_data, {p.b[4*w+3], p.b[4*w+2], p.b[4*w+1], p.b[4*w]});
      end
    end
    if (do_done) begin
      @(negedge CLK);
      pkt_done = 1'b1;
      @(negedge CLK);
      pkt_done = 1'b0;
      occ--;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_afull", {31'b0, afull}, 32'd1);
    check("rst_init_valid", {31'b0, init_valid}, 32'd0);
    check("rst_init_data", {27'b0, init_data}, 32'd0);
    check("rst_pkt_avail", {31'b0, pkt_avail}, 32'd0);
    check("rst_key_len", {25'b0, key_len}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
  endtask

  task automatic check_flow(input string tag);
    check({tag, "_ready"}, {31'b0, ready}, {31'b0, (occ < 2)});
    check({tag, "_afull"}, {31'b0, afull}, {31'b0, (occ == 2)});
  endtask

  // Consumer side: drains packets whenever auto mode is on.
  initial begin
    forever begin
      @(negedge CLK);
      if (cons_auto && pkt_avail === 1'b1) begin
        repeat ($urandom_range(0, 4)) @(negedge CLK);
        read_check_pkt(1'b1);
      end
    end
  end

  // Init monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (init_valid === 1'b1) begin
        if (exp_init_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL init_valid: got pulse with data 0x%0h, required no pulse", init_data);
        end else begin
          check("init_data", {27'b0, init_data}, {27'b0, exp_init_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned kl, len;
    RST_N = 1'b0;
    idle(3);
    check_reset_vals();
    RST_N = 1'b1;
    idle(1);
    check("post_rst_ready", {31'b0, ready}, 32'd1);
    check("post_rst_afull", {31'b0, afull}, 32'd0);

    // Single 48-byte packet, key_len 5.
    send_packet(48, 5, 1'b0);
    idle(2);
    check("t1_pkt_avail", {31'b0, pkt_avail}, 32'd1);
    check("t1_key_len", {25'b0, key_len}, 32'd5);
    check_flow("t1");
    check("t1_err", {31'b0, err}, 32'd0);

    // Second packet fills both slots.
    send_packet(52, 12, 1'b0);
    idle(2);
    check_flow("t2_full");
    read_check_pkt(1'b1);
    idle(2);
    check_flow("t2_rel");
    check("t2_pkt_avail", {31'b0, pkt_avail}, 32'd1);

    // Commit and release in the same cycle.
    read_check_pkt(1'b0);
    idle(1);
    send_packet(60, 20, 1'b1);
    idle(2);
    check("t5_pkt_avail", {31'b0, pkt_avail}, 32'd1);
    check_flow("t5");

    // Init byte strobed twice.
    send_init(5'h15);
    idle(3);
    check("t3_init_once", exp_init_q.size(), 32'd0);
    check("t3_init_data", {27'b0, init_data}, 32'h15);
    check("t3_err", {31'b0, err}, 32'd0);
    read_check_pkt(1'b1);
    idle(2);
    check("t5_drained", {31'b0, pkt_avail}, 32'd0);

    // key_len 9 with 48 bytes: accepted only without the length check.
    send_packet(48, 9, 1'b0);
    idle(2);
    check("t6_pkt_avail", {31'b0, pkt_avail}, {31'b0, pkt_ok(48, 9)});
    check("t6_err", {31'b0, err}, {31'b0, exp_err});
    if (exp_pkt_q.size() != 0) read_check_pkt(1'b1);
    idle(1);

    // Bad lengths, overflow into discard, then a good packet.
    wait_ready();
    send_packet(43, 5, 1'b0);
    idle(2);
    check("t4_short_err", {31'b0, err}, 32'd1);
    check("t4_short_avail", {31'b0, pkt_avail}, 32'd0);
    wait_ready();
    send_packet(105, 64, 1'b0);
    wait_ready();
    send_packet(110, 64, 1'b0);
    idle(2);
    check("t4_long_avail", {31'b0, pkt_avail}, 32'd0);
    wait_ready();
    send_packet(56, 16, 1'b0);
    idle(2);
    check("t4_next_avail", {31'b0, pkt_avail}, 32'd1);
    read_check_pkt(1'b1);
    idle(1);

    // Reset in the middle of a packet.
    wait_ready();
    strobe(8'h00, 1'b1);
    for (int i = 0; i < 20; i++) strobe(8'($urandom), 1'b0);
    RST_N = 1'b0;
    idle(1);
    check_reset_vals();
    exp_pkt_q.delete();
    exp_init_q.delete();
    occ = 0;
    exp_err = 1'b0;
    RST_N = 1'b1;
    idle(1);

    // Randomized traffic with the consumer draining on its own.
    cons_auto = 1'b1;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: send_init(5'($urandom));
        1: begin
          wait_ready();
          send_packet($urandom_range(30, 110), $urandom_range(1, 64), 1'b0);
        end
        default: begin
          kl  = $urandom_range(1, 64);
          len = 40 + ((kl + 3) / 4) * 4;
          wait_ready();
          send_packet(len, kl, 1'b0);
        end
      endcase
      idle($urandom_range(0, 3));
    end

    begin
      int k = 0;
      while ((exp_pkt_q.size() != 0 || pkt_avail === 1'b1) && k < 5000) begin
        idle(1);
        k++;
      end
    end
    idle(10);
    check("drain_queue", exp_pkt_q.size(), 32'd0);
    check("final_pkt_avail", {31'b0, pkt_avail}, 32'd0);
    check("final_init_q", exp_init_q.size(), 32'd0);
    check("final_err", {31'b0, err}, {31'b0, exp_err});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
